// File: rtl/dp_tap_ctrl.sv
// JTAG TAP controller for the debug boundary-scan chain: 16-state TAP FSM, IR,
// bypass and IDCODE registers, chain control generation and registered TDO.
module dp_tap_ctrl #(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic       iclk,
  input  logic       ireset,
  input  logic       tck_en,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_en,
  output logic       bsr_sdi,
  input  logic       bsr_sdo,
  output logic       mode,
  output logic       shift_dr,
  output logic       clk_dr,
  output logic       update_dr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  localparam logic [IR_W-1:0] IR_EXTEST  = '0;
  localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(2);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

  tap_state_t        r_state;
  tap_state_t        w_next;
  logic [IR_W-1:0]   r_ir;
  logic [IR_W-1:0]   r_ir_sh;
  logic              r_bypass;
  logic [31:0]       r_idcode;
  logic              r_tdo;
  logic              r_tdo_en;
  logic              w_sel_bsr;
  logic              w_sel_id;
  logic              w_sel_byp;
  logic              w_dr_bit0;

  // Data register selection from the active instruction; unknown codes fall to bypass
  assign w_sel_bsr = (r_ir == IR_EXTEST) || (r_ir == IR_SAMPLE);
  assign w_sel_id  = (r_ir == IR_IDCODE);
  assign w_sel_byp = !w_sel_bsr && !w_sel_id;
  assign w_dr_bit0 = w_sel_bsr ? bsr_sdo : (w_sel_id ? r_idcode[0] : r_bypass);

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= TLR;
    end else if (tck_en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:     w_next = tms ? TLR    : RTI;
      RTI:     w_next = tms ? SEL_DR : RTI;
      SEL_DR:  w_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:  w_next = tms ? EX1_DR : SH_DR;
      SH_DR:   w_next = tms ? EX1_DR : SH_DR;
      EX1_DR:  w_next = tms ? UPD_DR : PAU_DR;
      PAU_DR:  w_next = tms ? EX2_DR : PAU_DR;
      EX2_DR:  w_next = tms ? UPD_DR : SH_DR;
      UPD_DR:  w_next = tms ? SEL_DR : RTI;
      SEL_IR:  w_next = tms ? TLR    : CAP_IR;
      CAP_IR:  w_next = tms ? EX1_IR : SH_IR;
      SH_IR:   w_next = tms ? EX1_IR : SH_IR;
      EX1_IR:  w_next = tms ? UPD_IR : PAU_IR;
      PAU_IR:  w_next = tms ? EX2_IR : PAU_IR;
      EX2_IR:  w_next = tms ? UPD_IR : SH_IR;
      UPD_IR:  w_next = tms ? SEL_DR : RTI;
      default: w_next = TLR;
    endcase
  end

  // Chain pulses are gated by tck_en so cells act on the same iclk edge as the TAP
  always_comb begin
    state     = r_state;
    bsr_sdi   = tdi;
    mode      = (r_ir == IR_EXTEST);
    shift_dr  = (r_state == SH_DR);
    clk_dr    = tck_en && w_sel_bsr && ((r_state == CAP_DR) || (r_state == SH_DR));
    update_dr = tck_en && w_sel_bsr && (r_state == UPD_DR);
    tdo       = r_tdo;
    tdo_en    = r_tdo_en;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_ir     <= IR_IDCODE;
      r_ir_sh  <= '0;
      r_bypass <= 1'b0;
      r_idcode <= IDCODE_VAL;
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (tck_en) begin
      r_tdo_en <= (w_next == SH_IR) || (w_next == SH_DR);

      if (r_state == SH_IR) begin
        r_tdo <= r_ir_sh[0];
      end else if (r_state == SH_DR) begin
        r_tdo <= w_dr_bit0;
      end

      if (r_state == CAP_IR) begin
        r_ir_sh <= IR_CAPTURE;
      end else if (r_state == SH_IR) begin
        r_ir_sh <= {tdi, r_ir_sh[IR_W-1:1]};
      end

      // TLR entry overrides any pending instruction update
      if (w_next == TLR) begin
        r_ir <= IR_IDCODE;
      end else if (r_state == UPD_IR) begin
        r_ir <= r_ir_sh;
      end

      if (r_state == CAP_DR) begin
        r_idcode <= IDCODE_VAL;
        if (w_sel_byp) begin
          r_bypass <= 1'b0;
        end
      end else if (r_state == SH_DR) begin
        if (w_sel_id) begin
          r_idcode <= {tdi, r_idcode[31:1]};
        end
        if (w_sel_byp) begin
          r_bypass <= tdi;
        end
      end
    end
  end

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Bench for dp_tap_ctrl: directed TAP sequences plus random TMS/TDI traffic,
// all checked against a state-table reference model and an 8-cell chain model.
module tb_dp_tap_ctrl;
  localparam int          IR_W   = 4;
  localparam logic [31:0] IDV    = 32'h1000_0001;
  localparam logic [7:0]  PIN_IN = 8'h3C;

  localparam int S_TLR = 0, S_SH_DR = 4, S_CAP_DR = 3, S_PAU_DR = 6, S_UPD_DR = 8;
  localparam int S_CAP_IR = 10, S_SH_IR = 11, S_UPD_IR = 15;

  // Next-state tables straight from the transition list, indexed by state
  int N0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int N1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic       iclk = 1'b0;
  logic       ireset = 1'b0;
  logic       tck_en = 1'b0;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       tdo, tdo_en, bsr_sdi, bsr_sdo, mode, shift_dr, clk_dr, update_dr;
  logic [3:0] state;

  int n_assert = 0;
  int n_fail   = 0;
  int clk_cnt  = 0;
  int upd_cnt  = 0;

  logic [7:0] ch_sr   = 8'h00;
  logic [7:0] ch_pins = 8'h00;

  int          m_st;
  int          m_ir;
  int          m_irsh;
  logic        m_byp;
  logic [31:0] m_idc;
  logic        m_tdo;
  logic        m_tdo_en;

  dp_tap_ctrl #(.IR_W(IR_W), .IDCODE_VAL(IDV)) dut (
    .iclk(iclk), .ireset(ireset), .tck_en(tck_en), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .bsr_sdi(bsr_sdi), .bsr_sdo(bsr_sdo),
    .mode(mode), .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr),
    .state(state)
  );

  always #5 iclk = ~iclk;

  // Eight boundary-scan cells: new bit enters at the top, bit 0 feeds back as sdo
  assign bsr_sdo = ch_sr[0];
  always @(posedge iclk) begin
    if (clk_dr) begin
      ch_sr   <= shift_dr ? {bsr_sdi, ch_sr[7:1]} : PIN_IN;
      clk_cnt <= clk_cnt + 1;
    end
    if (update_dr) begin
      ch_pins <= ch_sr;
      upd_cnt <= upd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_TLR; m_ir = 2; m_irsh = 0; m_byp = 1'b0;
    m_idc = IDV; m_tdo = 1'b0; m_tdo_en = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_state"},  32'(state),  32'(m_st));
    chk({tag, "_tdo"},    32'(tdo),    32'(m_tdo));
    chk({tag, "_tdo_en"}, 32'(tdo_en), 32'(m_tdo_en));
    chk({tag, "_mode"},   32'(mode),   32'(m_ir == 0));
  endtask

  task automatic do_reset();
    @(negedge iclk);
    ireset = 1'b1; tck_en = 1'b0;
    @(posedge iclk); #1;
    ireset = 1'b0;
    model_reset();
    chk_regs("reset");
    chk("reset_clk_dr", 32'(clk_dr), 0);
    chk("reset_update_dr", 32'(update_dr), 0);
  endtask

  task automatic idle();
    @(negedge iclk);
    tck_en = 1'b0; tms = $urandom_range(0, 1); tdi = $urandom_range(0, 1);
    #1;
    chk("idle_clk_dr", 32'(clk_dr), 0);
    chk("idle_update_dr", 32'(update_dr), 0);
    @(posedge iclk); #1;
    chk_regs("idle");
  endtask

  task automatic tick(input logic tms_v, input logic tdi_v);
    int   nx;
    logic bsr, idsel, dbit;
    @(negedge iclk);
    tck_en = 1'b1; tms = tms_v; tdi = tdi_v;
    #1;
    bsr   = (m_ir == 0) || (m_ir == 1);
    idsel = (m_ir == 2);
    chk("shift_dr",  32'(shift_dr),  32'(m_st == S_SH_DR));
    chk("clk_dr",    32'(clk_dr),    32'(bsr && (m_st == S_CAP_DR || m_st == S_SH_DR)));
    chk("update_dr", 32'(update_dr), 32'(bsr && m_st == S_UPD_DR));
    chk("bsr_sdi",   32'(bsr_sdi),   32'(tdi_v));
    nx   = tms_v ? N1[m_st] : N0[m_st];
    dbit = bsr ? ch_sr[0] : (idsel ? m_idc[0] : m_byp);
    if (m_st == S_SH_IR) m_tdo = m_irsh[0];
    if (m_st == S_SH_DR) m_tdo = dbit;
    if (m_st == S_CAP_IR) m_irsh = 1;
    if (m_st == S_SH_IR)  m_irsh = m_irsh / 2 + (tdi_v ? (1 << (IR_W - 1)) : 0);
    if (m_st == S_UPD_IR) m_ir = m_irsh;
    if (m_st == S_CAP_DR) begin
      m_idc = IDV;
      if (!bsr && !idsel) m_byp = 1'b0;
    end
    if (m_st == S_SH_DR) begin
      if (idsel) m_idc = m_idc / 2 + (tdi_v ? 32'h8000_0000 : 32'h0);
      else if (!bsr) m_byp = tdi_v;
    end
    if (nx == S_TLR) m_ir = 2;
    m_tdo_en = (nx == S_SH_IR) || (nx == S_SH_DR);
    m_st = nx;
    @(posedge iclk); #1;
    tck_en = 1'b0;
    chk_regs("tick");
  endtask

  // Both scans start and end in RTI
  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      dout[i] = tdo;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic scan_ir(input logic [IR_W-1:0] din, output logic [IR_W-1:0] dout);
    dout = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) begin
      tick(i == IR_W - 1, din[i]);
      dout[i] = tdo;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0]     dw;
    logic [IR_W-1:0] iw;
    int              c0, u0;

    do_reset();
    idle();
    idle();

    c0 = clk_cnt;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("tlr_after_5", 32'(state), 0);
    chk("tlr_no_clk_dr", 32'(clk_cnt), 32'(c0));
    tick(1'b0, 1'b0);
    chk("rti_state", 32'(state), 1);

    c0 = clk_cnt;
    scan_dr(32, 32'hFFFF_0000, dw);
    chk("idcode_read", dw, 32'h1000_0001);
    chk("idcode_no_clk_dr", 32'(clk_cnt), 32'(c0));

    scan_ir('0, iw);
    chk("ir_capture_out", 32'(iw), 32'h1);
    chk("extest_mode", 32'(mode), 1);

    c0 = clk_cnt; u0 = upd_cnt;
    scan_dr(8, 32'hA5, dw);
    chk("extest_clk_pulses", 32'(clk_cnt - c0), 9);
    chk("extest_upd_pulses", 32'(upd_cnt - u0), 1);
    chk("extest_pins", 32'(ch_pins), 32'hA5);
    chk("extest_capture_out", dw & 32'hFF, 32'(PIN_IN));

    scan_ir('1, iw);
    chk("bypass_mode", 32'(mode), 0);
    c0 = clk_cnt; u0 = upd_cnt;
    scan_dr(9, 32'hA5, dw);
    chk("bypass_delay", dw, 32'h14A);
    chk("bypass_no_clk_dr", 32'(clk_cnt - c0), 0);
    chk("bypass_no_upd", 32'(upd_cnt - u0), 0);

    scan_ir('0, iw);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    c0 = clk_cnt;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("pause_state", 32'(state), 32'(S_PAU_DR));
    chk("pause_no_clk_dr", 32'(clk_cnt), 32'(c0));
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("resume_clk_dr", 32'(clk_cnt - c0), 1);
    chk("resume_tdo_en", 32'(tdo_en), 1);
    do_reset();
    chk("midshift_state", 32'(state), 0);
    chk("midshift_tdo_en", 32'(tdo_en), 0);
    idle();

    for (int it = 1; it <= 600; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (it % 97 == 0) begin
        for (int k = 0; k < 5; k++) tick(1'b1, $urandom_range(0, 1));
        chk("rand_tlr5", 32'(state), 0);
      end else if (r < 8) begin
        idle();
      end else if (r == 8) begin
        do_reset();
      end else begin
        tick(($urandom_range(0, 99) < 35), $urandom_range(0, 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
